pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle control sequencer that drives the program counter register of the non-pipelined MIPS core. It steps each instruction through fetch, decode, execute, memory and writeback phases, computes the next instruction address (PC+4, branch, jump, jump-register), and presents it on `memLoc` with a single clean `outputEnable` pulse. It sits between the instruction decoder/ALU and the PC register, whose current value it reads back as `currentPointer`.

## Interface
- No parameters; all datapaths are 32 bits (MIPS word).
- `clk` input 1: the single system clock. All state updates on its rising edge.
- `resetN` input 1: asynchronous, active-low reset.
- `currentPointer` input 32: PC register value fed back.
- `imemReady` input 1: instruction memory has returned the word.
- `dmemReady` input 1: data memory access has completed.
- `memOp` input 1: decoded instruction is a load or store.
- `branch` input 1: decoded conditional branch.
- `branchNe` input 1: 1 = bne, 0 = beq.
- `aluZero` input 1: ALU zero flag, valid in EXEC.
- `jump` input 1: j/jal.
- `jumpReg` input 1: jr.
- `halt` input 1: halt instruction decoded.
- `imm16` input 16: branch offset field.
- `target26` input 26: jump target field.
- `rsData` input 32: register rs value for jr.
- `memLoc` output 32: next PC value.
- `outputEnable` output 1: one-cycle PC load strobe.
- `imemReq` output 1: instruction fetch request.
- `dmemReq` output 1: data access request.
- `regWrite` output 1: writeback enable, high only in WB.
- `phase` output 3: current state encoding.
- `halted` output 1: core is stopped.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, PULSE=5, HALTED=6.
- FETCH: `imemReq`=1. Stay until `imemReady`, then go to DECODE.
- DECODE: register all decode inputs. If `halt`, go to HALTED; otherwise go to EXEC.
- EXEC: compute the next PC and load it into `memLoc` on exit. Go to MEM if `memOp`, else to WB.
- MEM: `dmemReq`=1. Stay until `dmemReady`, then go to WB.
- WB: `regWrite`=1 for one cycle, then go to PULSE.
- PULSE: `outputEnable`=1 for exactly one cycle, then go to FETCH.
- HALTED: absorbing state; `halted`=1. Only reset leaves it.
- Next-PC calculation, with pc4 = `currentPointer` + 4, all arithmetic modulo 2^32:
  - Priority is `jumpReg` > `jump` > taken branch > pc4.
  - jr: `rsData`.
  - j: {pc4[31:28], `target26`, 2'b00}.
  - Taken branch: pc4 + (signext(`imm16`) << 2). A branch is taken when `branch` & (`aluZero` ^ `branchNe`).
- Wrap-around: `currentPointer`=0xFFFFFFFC with no jump or branch gives `memLoc`=0x00000000. A negative offset below 0 wraps the same way.
- Decode inputs are sampled only in DECODE; changes in later phases are ignored. `aluZero` is sampled only in EXEC.

## Timing
- Reset values: `memLoc`=0, `outputEnable`=0, `imemReq`=0, `dmemReq`=0, `regWrite`=0, `halted`=0, `phase`=FETCH.
- `imemReq` asserts combinationally from the FETCH state in the first cycle after reset is released.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock. An in-flight `outputEnable` pulse is cut short.
- `outputEnable` is driven from a flop and is glitch-free. It is never high for two consecutive cycles.
- `memLoc` is stable for at least one full cycle before the `outputEnable` rising edge and throughout the pulse.
- Latency with `imemReady`/`dmemReady` high on the first request cycle:
  - Non-memory instruction: 5 cycles from FETCH entry to PULSE exit.
  - Memory instruction: 6 cycles.
  - Each ready-low cycle adds one cycle.
- `imemReq` and `dmemReq` stay high until their ready input is seen. They are never high together.

## Configuration
- `PC_ALIGN_CHECK_EN`:
  - Defined: in EXEC, a computed target with bits [1:0] ≠ 0 (possible only via jr) sends the FSM to HALTED. No `outputEnable` pulse is issued and `memLoc` keeps its previous value.
  - Undefined: the target is used unmodified and no check logic is present.

## Test plan
- Reset release with ready inputs tied high and plain ALU ops, starting from `currentPointer`=0x00000000: `outputEnable` pulses every 5 cycles; the first pulse carries `memLoc`=0x00000004.
- beq with `aluZero`=1, `imm16`=0xFFFF at PC 0x00000100 -> `memLoc`=0x00000100. Same with `aluZero`=0 -> `memLoc`=0x00000104. bne inverts both results.
- `jump` and `jumpReg` both high, `rsData`=0x00400020, `target26`=0x0000010 -> `memLoc`=0x00400020 (jr wins). j alone at PC 0x8000_0000 -> `memLoc`=0x80000040.
- Load with `dmemReady` held low for 3 cycles -> MEM lasts 4 cycles and the pulse arrives 9 cycles after FETCH entry. PC 0xFFFFFFFC with no branch -> `memLoc`=0x00000000.
- `resetN` dropped while in PULSE -> `outputEnable`, `memLoc` and `phase` are 0 immediately. `halt` in DECODE -> `halted`=1 and no further pulses or requests.
- Macro defined, jr to 0x00400022 -> HALTED with no pulse. Macro undefined, same stimulus -> `memLoc`=0x00400022.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: FETCH/DECODE/EXEC/MEM/WB/PULSE/HALTED control and next-PC selection.
// Optional PC_ALIGN_CHECK_EN halts on a misaligned computed target.
module pc_sequencer (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] currentPointer,
  input  logic        imemReady,
  input  logic        dmemReady,
  input  logic        memOp,
  input  logic        branch,
  input  logic        branchNe,
  input  logic        aluZero,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic        halt,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rsData,
  output logic [31:0] memLoc,
  output logic        outputEnable,
  output logic        imemReq,
  output logic        dmemReq,
  output logic        regWrite,
  output logic [2:0]  phase,
  output logic        halted
);

  // state  | meaning
  // FETCH  | request instruction word, wait for imemReady
  // DECODE | capture decoded fields
  // EXEC   | select next PC, load memLoc on exit
  // MEM    | request data access, wait for dmemReady
  // WB     | register writeback strobe
  // PULSE  | one-cycle PC load strobe
  // HALTED | stopped until reset
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    PULSE  = 3'd5,
    HALTED = 3'd6
  } stateT;

  stateT state, stateNext;

  logic        dMemOp, dBranch, dBranchNe, dJump, dJumpReg;
  logic [15:0] dImm16;
  logic [25:0] dTarget26;
  logic [31:0] dRsData, dPc;
  logic [31:0] pc4, branchTarget, nextPc;
  logic        taken, alignFault;
  logic        oeQ;

  always_comb begin
    pc4          = dPc + 32'd4;
    branchTarget = pc4 + {{14{dImm16[15]}}, dImm16, 2'b00};
    taken        = dBranch & (aluZero ^ dBranchNe);
    if (dJumpReg)   nextPc = dRsData;
    else if (dJump) nextPc = {pc4[31:28], dTarget26, 2'b00};
    else if (taken) nextPc = branchTarget;
    else            nextPc = pc4;
`ifdef PC_ALIGN_CHECK_EN
    alignFault = |nextPc[1:0];
`else
    alignFault = 1'b0;
`endif
  end

  always_comb begin
    stateNext = state;
    case (state)
      FETCH:   if (imemReady) stateNext = DECODE;
      DECODE:  stateNext = halt ? HALTED : EXEC;
      EXEC: begin
        if (alignFault)  stateNext = HALTED;
        else if (dMemOp) stateNext = MEM;
        else             stateNext = WB;
      end
      MEM:     if (dmemReady) stateNext = WB;
      WB:      stateNext = PULSE;
      PULSE:   stateNext = FETCH;
      HALTED:  stateNext = HALTED;
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= FETCH;
      oeQ       <= 1'b0;
      memLoc    <= 32'd0;
      dMemOp    <= 1'b0;
      dBranch   <= 1'b0;
      dBranchNe <= 1'b0;
      dJump     <= 1'b0;
      dJumpReg  <= 1'b0;
      dImm16    <= 16'd0;
      dTarget26 <= 26'd0;
      dRsData   <= 32'd0;
      dPc       <= 32'd0;
    end else begin
      state <= stateNext;
      // Strobe comes straight from a flop so the PC register sees no decode glitches
      oeQ   <= (stateNext == PULSE);
      if (state == DECODE) begin
        dMemOp    <= memOp;
        dBranch   <= branch;
        dBranchNe <= branchNe;
        dJump     <= jump;
        dJumpReg  <= jumpReg;
        dImm16    <= imm16;
        dTarget26 <= target26;
        dRsData   <= rsData;
        dPc       <= currentPointer;
      end
      if ((state == EXEC) && !alignFault) memLoc <= nextPc;
    end
  end

  // Reset gating keeps the fetch request low while reset is held
  assign imemReq      = resetN & (state == FETCH);
  assign dmemReq      = (state == MEM);
  assign regWrite     = (state == WB);
  assign halted       = (state == HALTED);
  assign phase        = state;
  assign outputEnable = oeQ;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed cases plus randomized instructions
// against a next-PC/phase-sequence reference model.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [31:0] currentPointer = '0;
  logic        imemReady = 1'b0, dmemReady = 1'b0, memOp = 1'b0, branch = 1'b0;
  logic        branchNe = 1'b0, aluZero = 1'b0, jump = 1'b0, jumpReg = 1'b0, halt = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;
  logic [31:0] rsData = '0;
  logic [31:0] memLoc;
  logic        outputEnable, imemReq, dmemReq, regWrite, halted;
  logic [2:0]  phase;

  int testsRun = 0, testsFailed = 0;
  logic [31:0] pc = '0;
  logic [31:0] lastLoc = '0;

  pc_sequencer dut (
    .clk(clk), .resetN(resetN), .currentPointer(currentPointer),
    .imemReady(imemReady), .dmemReady(dmemReady), .memOp(memOp),
    .branch(branch), .branchNe(branchNe), .aluZero(aluZero),
    .jump(jump), .jumpReg(jumpReg), .halt(halt), .imm16(imm16),
    .target26(target26), .rsData(rsData), .memLoc(memLoc),
    .outputEnable(outputEnable), .imemReq(imemReq), .dmemReq(dmemReq),
    .regWrite(regWrite), .phase(phase), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refNextPc(input logic [31:0] cur, input logic jr, input logic j,
                                            input logic br, input logic bne, input logic z,
                                            input logic [15:0] imm, input logic [25:0] tgt,
                                            input logic [31:0] rs);
    logic [31:0] p4;
    int off;
    p4 = cur + 32'd4;
    if (jr) return rs;
    if (j) return (p4 & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
    if (br && (z != bne)) begin
      off = $signed(imm);
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  task automatic scramble();
    memOp    = 1'($urandom);
    branch   = 1'($urandom);
    branchNe = 1'($urandom);
    jump     = 1'($urandom);
    jumpReg  = 1'($urandom);
    halt     = 1'($urandom);
    imm16    = 16'($urandom);
    target26 = 26'($urandom);
    rsData   = $urandom;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    #1;
    checkEq("rst_memLoc", memLoc, 32'd0);
    checkEq("rst_oe", 32'(outputEnable), 32'd0);
    checkEq("rst_imemReq", 32'(imemReq), 32'd0);
    checkEq("rst_dmemReq", 32'(dmemReq), 32'd0);
    checkEq("rst_regWrite", 32'(regWrite), 32'd0);
    checkEq("rst_halted", 32'(halted), 32'd0);
    checkEq("rst_phase", 32'(phase), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    pc = '0;
    lastLoc = '0;
    #1;
  endtask

  task automatic haltCheck();
    for (int i = 0; i < 4; i++) begin
      checkEq("halt_halted", 32'(halted), 32'd1);
      checkEq("halt_phase", 32'(phase), 32'd6);
      checkEq("halt_imemReq", 32'(imemReq), 32'd0);
      checkEq("halt_dmemReq", 32'(dmemReq), 32'd0);
      checkEq("halt_oe", 32'(outputEnable), 32'd0);
      checkEq("halt_memLoc", memLoc, lastLoc);
      imemReady = 1'b1;
      dmemReady = 1'b1;
      @(negedge clk);
    end
    imemReady = 1'b0;
    dmemReady = 1'b0;
    doReset();
  endtask

  // Steps one instruction from FETCH entry; k/m are ready-low cycles for imem/dmem.
  task automatic runInstr(input int k, input int m, input logic mOp, input logic br,
                          input logic bne, input logic z, input logic j, input logic jr,
                          input logic hlt, input logic [15:0] imm, input logic [25:0] tgt,
                          input logic [31:0] rs, input bit resetInPulse);
    logic [31:0] expPc;
    bit misalign;
    expPc = refNextPc(pc, jr, j, br, bne, z, imm, tgt, rs);
    misalign = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign = (expPc[1:0] != 2'b00);
`endif
    currentPointer = pc;
    for (int i = 0; i <= k; i++) begin
      checkEq("fetch_imemReq", 32'(imemReq), 32'd1);
      checkEq("fetch_phase", 32'(phase), 32'd0);
      checkEq("fetch_oe", 32'(outputEnable), 32'd0);
      imemReady = (i == k);
      memOp = mOp; branch = br; branchNe = bne; jump = j; jumpReg = jr; halt = hlt;
      imm16 = imm; target26 = tgt; rsData = rs;
      @(negedge clk);
    end
    imemReady = 1'b0;
    checkEq("decode_phase", 32'(phase), 32'd1);
    checkEq("decode_imemReq", 32'(imemReq), 32'd0);
    @(negedge clk);
    scramble();
    if (hlt) begin
      haltCheck();
      return;
    end
    checkEq("exec_phase", 32'(phase), 32'd2);
    checkEq("exec_memLoc_hold", memLoc, lastLoc);
    aluZero = z;
    @(negedge clk);
    aluZero = 1'($urandom);
    if (misalign) begin
      haltCheck();
      return;
    end
    if (mOp) begin
      for (int i = 0; i <= m; i++) begin
        checkEq("mem_dmemReq", 32'(dmemReq), 32'd1);
        checkEq("mem_imemReq", 32'(imemReq), 32'd0);
        checkEq("mem_phase", 32'(phase), 32'd3);
        dmemReady = (i == m);
        @(negedge clk);
      end
      dmemReady = 1'b0;
    end
    checkEq("wb_regWrite", 32'(regWrite), 32'd1);
    checkEq("wb_phase", 32'(phase), 32'd4);
    checkEq("wb_dmemReq", 32'(dmemReq), 32'd0);
    checkEq("wb_oe", 32'(outputEnable), 32'd0);
    checkEq("wb_memLoc", memLoc, expPc);
    @(negedge clk);
    checkEq("pulse_oe", 32'(outputEnable), 32'd1);
    checkEq("pulse_phase", 32'(phase), 32'd5);
    checkEq("pulse_regWrite", 32'(regWrite), 32'd0);
    checkEq("pulse_memLoc", memLoc, expPc);
    if (resetInPulse) begin
      #2 resetN = 1'b0;
      #1;
      checkEq("midrst_oe", 32'(outputEnable), 32'd0);
      checkEq("midrst_memLoc", memLoc, 32'd0);
      checkEq("midrst_phase", 32'(phase), 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      pc = '0;
      lastLoc = '0;
      #1;
      return;
    end
    @(negedge clk);
    checkEq("post_oe", 32'(outputEnable), 32'd0);
    pc = expPc;
    lastLoc = expPc;
  endtask

  initial begin
    @(negedge clk);
    doReset();
    // plain ALU ops from PC 0: pulses every 5 cycles, first memLoc 4
    runInstr(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0);
    checkEq("first_pc", pc, 32'h4);
    runInstr(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0);
    // beq/bne at 0x100 with imm16 = -1
    pc = 32'h100;
    runInstr(0, 0, 0, 1, 0, 1, 0, 0, 0, 16'hFFFF, 26'h0, 32'h0, 0);
    checkEq("beq_taken", lastLoc, 32'h100);
    pc = 32'h100;
    runInstr(0, 0, 0, 1, 0, 0, 0, 0, 0, 16'hFFFF, 26'h0, 32'h0, 0);
    checkEq("beq_not_taken", lastLoc, 32'h104);
    pc = 32'h100;
    runInstr(0, 0, 0, 1, 1, 1, 0, 0, 0, 16'hFFFF, 26'h0, 32'h0, 0);
    checkEq("bne_not_taken", lastLoc, 32'h104);
    pc = 32'h100;
    runInstr(0, 0, 0, 1, 1, 0, 0, 0, 0, 16'hFFFF, 26'h0, 32'h0, 0);
    checkEq("bne_taken", lastLoc, 32'h100);
    // jr beats j; j alone
    runInstr(1, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0, 26'h10, 32'h0040_0020, 0);
    checkEq("jr_wins", lastLoc, 32'h0040_0020);
    pc = 32'h8000_0000;
    runInstr(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 26'h10, 32'h0, 0);
    checkEq("j_target", lastLoc, 32'h8000_0040);
    // load with dmemReady low 3 cycles; wrap at top of address space
    pc = 32'hFFFF_FFFC;
    runInstr(0, 3, 1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0);
    checkEq("wrap_pc", lastLoc, 32'h0);
    // negative branch offset below zero
    pc = 32'h0;
    runInstr(2, 1, 1, 1, 0, 1, 0, 0, 0, 16'hFFFC, 26'h0, 32'h0, 0);
    checkEq("neg_wrap", lastLoc, 32'hFFFF_FFF4);
    // reset during PULSE
    runInstr(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 1);
    // halt in DECODE
    runInstr(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h0, 0);
    // misaligned jr
    pc = 32'h40;
    runInstr(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0, 26'h0, 32'h0040_0022, 0);
`ifndef PC_ALIGN_CHECK_EN
    checkEq("jr_misaligned", lastLoc, 32'h0040_0022);
`endif
    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic hlt, jr;
      hlt = ($urandom_range(0, 15) == 0);
      jr  = ($urandom_range(0, 5) == 0);
      runInstr($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), jr, hlt, 16'($urandom),
               26'($urandom), $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 19) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
